// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter that owns the select line of a 2:1 mux.
// Each owner may move up to MAX_BURST beats while the other requester waits.
// The shared output uses a valid/ready handshake. select is always a
// registered value, so out_data only changes relative to select on clock edges.
module mux2_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic [1:0]       gnt,
    output logic             select,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    state_t           state_q, state_d;
    logic             select_q, select_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic owner;       // requester index implied by the OWNx state
    logic owner_req;
    logic other_req;
    logic xfer;
    logic take;        // hand ownership to take_id this cycle
    logic take_id;

    // Handshake outputs; forced quiet while reset is asserted so no beat is granted in the reset cycle
    always_comb begin
        owner     = (state_q == OWN1);
        owner_req = req[owner];
        other_req = req[~owner];
        out_valid = ~reset & (((state_q == OWN0) & req[0]) | ((state_q == OWN1) & req[1]));
        xfer      = out_valid & out_ready;
        gnt       = {xfer & select_q, xfer & ~select_q};
        select    = select_q;
        out_data  = select_q ? data1 : data0;
    end

    // Arbitration: pick the next owner, count beats and apply the burst limit
    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        take     = 1'b0;
        take_id  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req == 2'b11) begin
                    // Both asking: the requester not served last goes first
                    take    = 1'b1;
                    take_id = ~last_q;
                end else if (req[0]) begin
                    take    = 1'b1;
                    take_id = 1'b0;
                end else if (req[1]) begin
                    take    = 1'b1;
                    take_id = 1'b1;
                end
            end
            OWN0, OWN1: begin
                if (!owner_req) begin
                    // Owner went away: hand over (one bubble cycle) or go idle keeping select
                    if (other_req) begin
                        take    = 1'b1;
                        take_id = ~owner;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    if (cnt_q == LAST_BEAT) begin
                        // Burst exhausted: yield only if the other side is waiting
                        cnt_d = '0;
                        if (other_req) begin
                            take    = 1'b1;
                            take_id = ~owner;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                // Stalled beats (out_ready low) leave state and count untouched
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            state_d  = take_id ? OWN1 : OWN0;
            select_d = take_id;
            last_d   = take_id;
            cnt_d    = '0;
        end
    end

    // State registers with synchronous reset; last=1 makes requester 0 win the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            select_q <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
